// File: rtl/uart_rx_if.sv
// Receive-side holding-register handshake between uart_rx and the register block.
// The master is the receiver; the slave is the consumer that raises rx_ready.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampled UART receiver: 2-flop synchronizer, centre-sampling FSM and a
// one-entry holding register carrying the byte plus its frame/parity flags.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      tick,
    input  logic      rxd,
    uart_rx_if.master rx_bus,
    output logic      overrun,
    output logic      busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [SW-1:0] S_HALF   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);
    localparam logic          ODD_BIT  = (PARITY_ODD != 0);
    localparam logic          PAR_ON   = (PARITY_EN != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        s_cnt_q, s_cnt_d;
    logic [BW-1:0]        b_cnt_q, b_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 overrun_q, overrun_d;
    logic                 meta_q, rxd_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s_cnt_q   <= '0;
            b_cnt_q   <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            armed_q   <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
            meta_q    <= 1'b1;
            rxd_s_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            b_cnt_q   <= b_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            armed_q   <= armed_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            overrun_q <= overrun_d;
            meta_q    <= rxd;
            rxd_s_q   <= meta_q;
        end
    end

    // armed_q blocks a new start after a low stop bit (break) until the line has been high again
    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        b_cnt_d   = b_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        armed_d   = armed_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        overrun_d = 1'b0;

        if (valid_q && rx_bus.rx_ready)
            valid_d = 1'b0;
        if (rxd_s_q)
            armed_d = 1'b1;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s_q && armed_q) begin
                        state_d = START;
                        s_cnt_d = '0;
                    end
                end
                START: begin
                    s_cnt_d = s_cnt_q + SW'(1);
                    if (s_cnt_q == S_HALF) begin
                        if (rxd_s_q) begin
                            state_d = IDLE;
                            s_cnt_d = '0;
                        end else begin
                            state_d   = DATA;
                            s_cnt_d   = '0;
                            b_cnt_d   = '0;
                            par_err_d = 1'b0;
                        end
                    end
                end
                DATA: begin
                    s_cnt_d = s_cnt_q + SW'(1);
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                        b_cnt_d = b_cnt_q + BW'(1);
                        if (b_cnt_q == B_LAST)
                            state_d = PAR_ON ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    s_cnt_d = s_cnt_q + SW'(1);
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d   = '0;
                        par_err_d = ((^shift_q) ^ rxd_s_q) != ODD_BIT;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    s_cnt_d = s_cnt_q + SW'(1);
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        state_d = IDLE;
                        if (!rxd_s_q)
                            armed_d = 1'b0;
                        if (!valid_q || rx_bus.rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            ferr_d  = ~rxd_s_q;
                            perr_d  = PAR_ON & par_err_q;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_bus.rx_data    = data_q;
    assign rx_bus.rx_valid   = valid_q;
    assign rx_bus.frame_err  = ferr_q;
    assign rx_bus.parity_err = perr_q;
    assign overrun           = overrun_q;
    assign busy              = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance sharing clock,
// reset and tick, with frames bit-banged on negedges and outputs checked between edges.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic txLine = 1'b1;
    int   rxdSel = 0;
    logic rxd0, rxd1;
    logic overrun0, overrun1, busy0, busy1;

    int   tickDiv = 1;
    int   tickCnt = 0;
    int   cycleCnt = 0;
    int   riseCycle = 0;
    int   startCycle = 0;
    int   overrunCnt = 0;
    logic prevValid0 = 1'b0;

    int checks = 0;
    int failures = 0;

    uart_rx_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_if #(.DATA_BITS(8)) bus1 ();

    assign rxd0 = (rxdSel == 0) ? txLine : 1'b1;
    assign rxd1 = (rxdSel == 1) ? txLine : 1'b1;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .rxd     (rxd0),
        .rx_bus  (bus0),
        .overrun (overrun0),
        .busy    (busy0)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .rxd     (rxd1),
        .rx_bus  (bus1),
        .overrun (overrun1),
        .busy    (busy1)
    );

    always #5 clk = ~clk;

    // tick is one clk wide, once every tickDiv clocks
    always @(negedge clk) begin
        if (tickCnt >= tickDiv - 1) begin
            tick = 1'b1;
            tickCnt = 0;
        end else begin
            tick = 1'b0;
            tickCnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        cycleCnt++;
        if (bus0.rx_valid && !prevValid0)
            riseCycle = cycleCnt;
        prevValid0 = bus0.rx_valid;
        if (overrun0)
            overrunCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic driveBit(input logic b);
        txLine = b;
        waitClks(16 * tickDiv);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic withParity,
                                 input logic parityBit, input logic stopBit);
        startCycle = cycleCnt;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++)
            driveBit(data[i]);
        if (withParity)
            driveBit(parityBit);
        driveBit(stopBit);
        txLine = 1'b1;
    endtask

    task automatic popByte(input int sel);
        if (sel == 0) bus0.rx_ready = 1'b1;
        else          bus1.rx_ready = 1'b1;
        waitClks(1);
        bus0.rx_ready = 1'b0;
        bus1.rx_ready = 1'b0;
    endtask

    task automatic runBasic(input int div);
        logic [7:0] abortByte;
        tickDiv = div;
        rxdSel = 0;
        waitClks(8);

        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1);
        checkOutput("a5_valid", bus0.rx_valid, 1);
        checkOutput("a5_data", bus0.rx_data, 32'hA5);
        checkOutput("a5_ferr", bus0.frame_err, 0);
        checkOutput("a5_perr", bus0.parity_err, 0);
        checkOutput("a5_latency_win",
                    ((riseCycle - startCycle) >= 148 * div) && ((riseCycle - startCycle) <= 162 * div), 1);
        popByte(0);
        checkOutput("a5_pop_valid", bus0.rx_valid, 0);
        checkOutput("a5_pop_data_kept", bus0.rx_data, 32'hA5);

        txLine = 1'b0;
        waitClks(5 * div);
        checkOutput("glitch_busy", busy0, 1);
        txLine = 1'b1;
        waitClks(16 * div);
        checkOutput("glitch_idle", busy0, 0);
        checkOutput("glitch_novalid", bus0.rx_valid, 0);

        applyStimulus(8'h01, 1'b0, 1'b0, 1'b1);
        checkOutput("b01_valid", bus0.rx_valid, 1);
        checkOutput("b01_data", bus0.rx_data, 32'h01);

        // Byte 0x01 stays held while a second frame is cut off by reset in bit 4
        abortByte = 8'h55;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++)
            driveBit(abortByte[i]);
        txLine = abortByte[4];
        waitClks(8 * div);
        rst = 1'b1;
        waitClks(1);
        rst = 1'b0;
        checkOutput("rst_valid", bus0.rx_valid, 0);
        checkOutput("rst_data", bus0.rx_data, 0);
        checkOutput("rst_ferr", bus0.frame_err, 0);
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_overrun", overrun0, 0);
        txLine = 1'b1;
        waitClks(32 * div);
        checkOutput("rst_no_delivery", bus0.rx_valid, 0);

        applyStimulus(8'h55, 1'b0, 1'b0, 1'b1);
        checkOutput("b55_valid", bus0.rx_valid, 1);
        checkOutput("b55_data", bus0.rx_data, 32'h55);
        checkOutput("b55_ferr", bus0.frame_err, 0);
        popByte(0);
        checkOutput("b55_pop", bus0.rx_valid, 0);
    endtask

    initial begin
        bus0.rx_ready = 1'b0;
        bus1.rx_ready = 1'b0;
        rst = 1'b1;
        waitClks(3);
        checkOutput("reset_valid", bus0.rx_valid, 0);
        checkOutput("reset_data", bus0.rx_data, 0);
        checkOutput("reset_busy", busy0, 0);
        checkOutput("reset_overrun", overrun0, 0);
        checkOutput("reset_ferr", bus0.frame_err, 0);
        rst = 1'b0;

        runBasic(1);

        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1);
        waitClks(16);
        overrunCnt = 0;
        applyStimulus(8'hC3, 1'b0, 1'b0, 1'b1);
        waitClks(16);
        checkOutput("ovr_pulse_count", overrunCnt, 1);
        checkOutput("ovr_valid", bus0.rx_valid, 1);
        checkOutput("ovr_data_kept", bus0.rx_data, 32'h3C);
        checkOutput("ovr_ferr", bus0.frame_err, 0);
        popByte(0);

        applyStimulus(8'h7E, 1'b0, 1'b0, 1'b0);
        checkOutput("stop0_valid", bus0.rx_valid, 1);
        checkOutput("stop0_data", bus0.rx_data, 32'h7E);
        checkOutput("stop0_ferr", bus0.frame_err, 1);
        popByte(0);
        applyStimulus(8'h7E, 1'b0, 1'b0, 1'b1);
        checkOutput("stop1_data", bus0.rx_data, 32'h7E);
        checkOutput("stop1_ferr", bus0.frame_err, 0);
        popByte(0);

        txLine = 1'b0;
        waitClks(12 * 16);
        checkOutput("break_valid", bus0.rx_valid, 1);
        checkOutput("break_data", bus0.rx_data, 0);
        checkOutput("break_ferr", bus0.frame_err, 1);
        checkOutput("break_idle", busy0, 0);
        waitClks(32);
        checkOutput("break_stay_idle", busy0, 0);
        txLine = 1'b1;
        popByte(0);
        waitClks(32);
        checkOutput("break_no_refire", bus0.rx_valid, 0);

        rxdSel = 1;
        waitClks(8);
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
        checkOutput("par_ok_valid", bus1.rx_valid, 1);
        checkOutput("par_ok_data", bus1.rx_data, 32'h07);
        checkOutput("par_ok_perr", bus1.parity_err, 0);
        checkOutput("par_ok_ferr", bus1.frame_err, 0);
        popByte(1);
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
        checkOutput("par_bad_data", bus1.rx_data, 32'h07);
        checkOutput("par_bad_perr", bus1.parity_err, 1);
        checkOutput("par_overrun", overrun1, 0);
        popByte(1);
        checkOutput("par_pop", bus1.rx_valid, 0);
        checkOutput("par_busy", busy1, 0);
        rxdSel = 0;

        runBasic(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the APB UART. It recovers serial frames from the rxd line using the oversampled tick produced by the baud rate generator.
- It samples each bit at its centre, checks optional parity and the stop bit, and presents each received byte through a one-entry valid/ready holding register.
- It sits between the pad-side rxd line and the APB register block, which reads the RX data register and raises the ready strobe.

Parameters:
- DATA_BITS, 8: data bits per frame (5..8), sent LSB first.
- OVERSAMPLE, 16: tick pulses per bit period; even and at least 4. The generator's divider is set to CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE).
- PARITY_EN, 0: 1 means a parity bit follows the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- tick  input  1  oversample strobe from the baud generator; one clk wide, OVERSAMPLE per bit.
- rxd  input  1  asynchronous serial input; idle high.
- rx_data  output  DATA_BITS  received data, valid while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts; the pop happens when rx_valid&rx_ready.
- frame_err  output  1  stop bit sampled low for the held byte; valid with rx_valid.
- parity_err  output  1  parity mismatch for the held byte; valid with rx_valid. Always 0 when PARITY_EN=0.
- overrun  output  1  one-clk pulse when a completed frame is dropped.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: when rst=1 at a clk edge, all of the following take effect.
  - rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
  - Reset mid-frame abandons the frame; nothing is delivered.
- rxd passes through a 2-flop synchronizer (rxd_s). All decisions use rxd_s.
- Sampling rules:
  - State logic advances only on cycles with tick=1, except the holding-register pop and the overrun pulse.
  - s_cnt counts ticks within a bit, width $clog2(OVERSAMPLE).
  - b_cnt counts data bits, width $clog2(DATA_BITS)+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with rxd_s=0, go to START with s_cnt=0.
  - START: on each tick s_cnt++. At s_cnt==OVERSAMPLE/2-1 (bit centre):
    - if rxd_s=1, this is a false start: return to IDLE.
    - else go to DATA with s_cnt=0, b_cnt=0.
  - DATA: on each tick s_cnt++. At s_cnt==OVERSAMPLE-1:
    - shift rxd_s into shift-reg MSB (right shift, so LSB-first ends aligned), s_cnt=0, b_cnt++.
    - After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
  - PARITY: at s_cnt==OVERSAMPLE-1, sample the bit, compute the parity error flag, go to STOP, s_cnt=0.
    - Even parity: error if XOR(data,p)!=0.
    - Odd parity: error if XOR(data,p)!=1.
  - STOP: at s_cnt==OVERSAMPLE-1, sample the stop bit, then:
    - if rx_valid=0, or rx_ready=1 in the same cycle: load rx_data, frame_err=~rxd_s, parity_err; set rx_valid=1 on the next clk edge.
    - else: drop the frame, pulse overrun for 1 clk, leave the held byte and its flags unchanged.
    - In both cases return to IDLE, so a new start bit can be detected from the next tick.
- Latency: rx_valid rises 1 clk after the tick that samples the stop-bit centre.
- Holding register:
  - rx_valid&rx_ready clears rx_valid on the next edge.
  - rx_data and the flags keep their old values after the pop until the next load.
  - A pop on the same edge as a load results in the new byte valid.
- Break (rxd held low) is delivered as data 0 with frame_err=1. The receiver then stays in IDLE until rxd_s returns high and falls again.
- tick=0 freezes the FSM indefinitely; the pop and reset remain functional.

Test Plan:
- Set tick=1 every clk, OVERSAMPLE=16, 8N1, and send 0xA5 (LSB first, 16 clk/bit). Required: rx_valid=1 ~152 clks after the start edge, rx_data=0xA5, frame_err=0, parity_err=0. Pulse rx_ready: rx_valid=0 on the next clk.
- Send two frames 0x3C then 0xC3 with rx_ready held 0. Required: rx_data stays 0x3C, overrun pulses for exactly 1 clk at the end of the second frame, rx_valid stays 1.
- Pull rxd low for 5 ticks only (a glitch shorter than half a bit). Required: return to IDLE, busy falls, no rx_valid. A following real frame 0x01 is received correctly.
- Send 0x7E with the stop bit driven 0. Required: rx_data=0x7E, frame_err=1. Then send 0x7E with a correct stop bit: frame_err=0.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity 1 (correct), then parity 0. Required: parity_err=0, then parity_err=1.
- Assert rst=1 for 1 clk midway through data bit 4. Required: all outputs reach reset values on the next edge, no byte is delivered, and a subsequent frame 0x55 is received intact. Also run with tick pulsing every 3rd clk and check the same results at 3× the latency.
